// File: rtl/riscv_lsu_pkg.sv
// riscv_lsu_pkg: shared opcode/funct3 constants, LSU state encoding,
// captured-request struct and the misalignment predicate.
// Used by riscv_lsu, riscv_lsu_align and riscv_lsu_if.
package riscv_lsu_pkg;

   localparam int XLEN   = 32;
   localparam int MEM_AW = XLEN - 2;

   localparam logic [6:0] OPCODE_LOAD  = 7'b0000011;
   localparam logic [6:0] OPCODE_STORE = 7'b0100011;

   localparam logic [2:0] FUNCT3_LOAD_LB  = 3'b000;
   localparam logic [2:0] FUNCT3_LOAD_LH  = 3'b001;
   localparam logic [2:0] FUNCT3_LOAD_LW  = 3'b010;
   localparam logic [2:0] FUNCT3_LOAD_LBU = 3'b100;
   localparam logic [2:0] FUNCT3_LOAD_LHU = 3'b101;

   localparam logic [2:0] FUNCT3_STORE_SB = 3'b000;
   localparam logic [2:0] FUNCT3_STORE_SH = 3'b001;
   localparam logic [2:0] FUNCT3_STORE_SW = 3'b010;

   typedef enum logic [1:0] {
      LSU_IDLE,
      LSU_ISSUE,
      LSU_WAIT,
      LSU_RESP
   } lsu_state_e;

   // Fields of an accepted request needed after the accept cycle.
   typedef struct packed {
      logic       store;
      logic [2:0] funct3;
      logic [1:0] off;
   } lsu_op_t;

   // Undefined funct3 encodings behave as word accesses, so they need off==0.
   function automatic logic lsu_is_misaligned(input logic store, input logic [2:0] funct3,
                                              input logic [1:0] off);
      logic mis;
      if (store) begin
         case (funct3)
            FUNCT3_STORE_SB: mis = 1'b0;
            FUNCT3_STORE_SH: mis = off[0];
            default:         mis = (off != 2'b00);
         endcase
      end else begin
         case (funct3)
            FUNCT3_LOAD_LB, FUNCT3_LOAD_LBU: mis = 1'b0;
            FUNCT3_LOAD_LH, FUNCT3_LOAD_LHU: mis = off[0];
            default:                         mis = (off != 2'b00);
         endcase
      end
      return mis;
   endfunction

endpackage

// File: rtl/riscv_lsu_if.sv
// riscv_lsu_if: request, data-memory and response signals of the LSU.
// modport slave  : the LSU view (request/memory-return in, memory/response out)
// modport master : the environment view (decode + memory + writeback)
interface riscv_lsu_if;
   import riscv_lsu_pkg::*;

   logic              req_valid;
   logic              req_ready;
   logic              req_store;
   logic [2:0]        req_funct3;
   logic [XLEN-1:0]   req_addr;
   logic [XLEN-1:0]   req_wdata;

   logic              mem_valid;
   logic              mem_ready;
   logic [MEM_AW-1:0] mem_addr;
   logic              mem_we;
   logic [3:0]        mem_wstrb;
   logic [XLEN-1:0]   mem_wdata;
   logic              mem_rvalid;
   logic [XLEN-1:0]   mem_rdata;

   logic              resp_valid;
   logic [XLEN-1:0]   resp_rdata;
   logic              resp_fault;

   modport slave (
      input  req_valid, req_store, req_funct3, req_addr, req_wdata,
      input  mem_ready, mem_rvalid, mem_rdata,
      output req_ready, mem_valid, mem_addr, mem_we, mem_wstrb, mem_wdata,
      output resp_valid, resp_rdata, resp_fault
   );

   modport master (
      output req_valid, req_store, req_funct3, req_addr, req_wdata,
      output mem_ready, mem_rvalid, mem_rdata,
      input  req_ready, mem_valid, mem_addr, mem_we, mem_wstrb, mem_wdata,
      input  resp_valid, resp_rdata, resp_fault
   );

endinterface

// File: rtl/riscv_lsu_align.sv
// riscv_lsu_align: combinational byte-lane logic.
//   store/funct3/off : access descriptor (off = byte address [1:0])
//   wdata            : right-aligned store data
//   rdata            : raw memory word
//   wstrb            : byte strobes (0 for loads)
//   wdata_lane       : lane-replicated store data
//   rdata_ext        : extracted and sign/zero-extended load data
// Sub-halfword offsets on SH are ignored (off[1] selects the half).
module riscv_lsu_align
   import riscv_lsu_pkg::*;
(
   input  logic            store,
   input  logic [2:0]      funct3,
   input  logic [1:0]      off,
   input  logic [XLEN-1:0] wdata,
   input  logic [XLEN-1:0] rdata,
   output logic [3:0]      wstrb,
   output logic [XLEN-1:0] wdata_lane,
   output logic [XLEN-1:0] rdata_ext
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   always_comb begin
      byte_v     = rdata[{off, 3'b000} +: 8];
      half_v     = rdata[{off[1], 4'b0000} +: 16];
      wstrb      = 4'b0000;
      wdata_lane = wdata;
      rdata_ext  = rdata;
      if (store) begin
         case (funct3)
            FUNCT3_STORE_SB: begin
               wstrb      = 4'b0001 << off;
               wdata_lane = {4{wdata[7:0]}};
            end
            FUNCT3_STORE_SH: begin
               wstrb      = off[1] ? 4'b1100 : 4'b0011;
               wdata_lane = {2{wdata[15:0]}};
            end
            default: wstrb = 4'b1111;
         endcase
      end else begin
         case (funct3)
            FUNCT3_LOAD_LB:  rdata_ext = {{24{byte_v[7]}}, byte_v};
            FUNCT3_LOAD_LBU: rdata_ext = {24'h0, byte_v};
            FUNCT3_LOAD_LH:  rdata_ext = {{16{half_v[15]}}, half_v};
            FUNCT3_LOAD_LHU: rdata_ext = {16'h0, half_v};
            default:         rdata_ext = rdata;
         endcase
      end
   end

endmodule

// File: rtl/riscv_lsu.sv
// riscv_lsu: load/store unit, single outstanding word-wide memory access.
//   clk, reset : clock, synchronous active-high reset
//   bus        : riscv_lsu_if.slave (request in, memory port, response out)
// Flow: IDLE (accept) -> ISSUE (mem_valid until mem_ready) -> WAIT (mem_rvalid)
//       -> RESP (one-cycle resp_valid). Zero-wait latency is 3 cycles.
// Optional: LSU_MISALIGN_TRAP_EN makes misaligned requests skip memory and
// respond with resp_fault=1; otherwise resp_fault is tied 0.
module riscv_lsu
   import riscv_lsu_pkg::*;
(
   input  logic      clk,
   input  logic      reset,
   riscv_lsu_if.slave bus
);

   lsu_state_e        state_q, state_d;
   lsu_op_t           op_q, op_d, op_sel;
   logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
   logic              mem_we_q, mem_we_d;
   logic [3:0]        wstrb_q, wstrb_d;
   logic [XLEN-1:0]   wdata_q, wdata_d;
   logic [XLEN-1:0]   rdata_q, rdata_d;
   logic [3:0]        al_wstrb;
   logic [XLEN-1:0]   al_wdata, al_rdata;
   logic              misalign;

`ifdef LSU_MISALIGN_TRAP_EN
   logic fault_q, fault_d;
   assign misalign       = lsu_is_misaligned(bus.req_store, bus.req_funct3, bus.req_addr[1:0]);
   assign bus.resp_fault = fault_q;
`else
   assign misalign       = 1'b0;
   assign bus.resp_fault = 1'b0;
`endif

   // The aligner sees the live request while idle (for strobes/lanes) and the
   // captured request afterwards (for load extraction).
   always_comb begin
      op_sel = op_q;
      if (state_q == LSU_IDLE) begin
         op_sel.store  = bus.req_store;
         op_sel.funct3 = bus.req_funct3;
         op_sel.off    = bus.req_addr[1:0];
      end
   end

   riscv_lsu_align u_align (
      .store      (op_sel.store),
      .funct3     (op_sel.funct3),
      .off        (op_sel.off),
      .wdata      (bus.req_wdata),
      .rdata      (bus.mem_rdata),
      .wstrb      (al_wstrb),
      .wdata_lane (al_wdata),
      .rdata_ext  (al_rdata)
   );

   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      mem_addr_d = mem_addr_q;
      mem_we_d   = mem_we_q;
      wstrb_d    = wstrb_q;
      wdata_d    = wdata_q;
      rdata_d    = rdata_q;
`ifdef LSU_MISALIGN_TRAP_EN
      fault_d    = fault_q;
`endif
      case (state_q)
         LSU_IDLE: begin
            if (bus.req_valid) begin
               op_d       = op_sel;
               mem_addr_d = bus.req_addr[XLEN-1:2];
               mem_we_d   = bus.req_store;
               wstrb_d    = al_wstrb;
               wdata_d    = al_wdata;
               rdata_d    = '0;
`ifdef LSU_MISALIGN_TRAP_EN
               fault_d    = misalign;
`endif
               state_d    = misalign ? LSU_RESP : LSU_ISSUE;
            end
         end
         LSU_ISSUE: if (bus.mem_ready) state_d = LSU_WAIT;
         LSU_WAIT: begin
            if (bus.mem_rvalid) begin
               rdata_d = op_q.store ? '0 : al_rdata;
               state_d = LSU_RESP;
            end
         end
         default: state_d = LSU_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= LSU_IDLE;
         op_q       <= '0;
         mem_addr_q <= '0;
         mem_we_q   <= 1'b0;
         wstrb_q    <= '0;
         wdata_q    <= '0;
         rdata_q    <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
         fault_q    <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         mem_addr_q <= mem_addr_d;
         mem_we_q   <= mem_we_d;
         wstrb_q    <= wstrb_d;
         wdata_q    <= wdata_d;
         rdata_q    <= rdata_d;
`ifdef LSU_MISALIGN_TRAP_EN
         fault_q    <= fault_d;
`endif
      end
   end

   // req_ready is masked during reset so it reads 0 while reset is held.
   assign bus.req_ready  = (state_q == LSU_IDLE) && !reset;
   assign bus.mem_valid  = (state_q == LSU_ISSUE);
   assign bus.resp_valid = (state_q == LSU_RESP);
   assign bus.mem_addr   = mem_addr_q;
   assign bus.mem_we     = mem_we_q;
   assign bus.mem_wstrb  = wstrb_q;
   assign bus.mem_wdata  = wdata_q;
   assign bus.resp_rdata = rdata_q;

endmodule

// File: tb/tb_riscv_lsu.sv
// tb_riscv_lsu: directed table-driven bench for riscv_lsu, plus hand-written
// reset-in-flight sequence. Inputs change and outputs are sampled 1ns after
// the rising edge.
module tb_riscv_lsu;
   import riscv_lsu_pkg::*;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   failures = 0;

   riscv_lsu_if bus ();

   riscv_lsu dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        store;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic [29:0] maddr;
      logic [3:0]  strb;
      logic [31:0] mwdata;
      logic [31:0] resp;
      int          dly;
      logic        mis;
   } vec_t;

   vec_t vt[$];

   function automatic vec_t mk(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wd, input logic [31:0] rd, input logic [29:0] ma,
                               input logic [3:0] sb, input logic [31:0] mw, input logic [31:0] rs,
                               input int dly, input logic mis);
      vec_t v;
      v.store = st; v.f3 = f3; v.addr = addr; v.wdata = wd; v.rdata = rd;
      v.maddr = ma; v.strb = sb; v.mwdata = mw; v.resp = rs; v.dly = dly; v.mis = mis;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_req_ready"},  32'(bus.req_ready),  32'h0);
      chk({tag, "_mem_valid"},  32'(bus.mem_valid),  32'h0);
      chk({tag, "_mem_we"},     32'(bus.mem_we),     32'h0);
      chk({tag, "_mem_wstrb"},  32'(bus.mem_wstrb),  32'h0);
      chk({tag, "_mem_addr"},   32'(bus.mem_addr),   32'h0);
      chk({tag, "_mem_wdata"},  bus.mem_wdata,       32'h0);
      chk({tag, "_resp_valid"}, 32'(bus.resp_valid), 32'h0);
      chk({tag, "_resp_rdata"}, bus.resp_rdata,      32'h0);
      chk({tag, "_resp_fault"}, 32'(bus.resp_fault), 32'h0);
   endtask

   task automatic chk_mem(input string tag, input vec_t v);
      chk({tag, "_mem_valid"}, 32'(bus.mem_valid), 32'h1);
      chk({tag, "_mem_addr"},  32'(bus.mem_addr),  32'(v.maddr));
      chk({tag, "_mem_we"},    32'(bus.mem_we),    32'(v.store));
      chk({tag, "_mem_wstrb"}, 32'(bus.mem_wstrb), 32'(v.strb));
      if (v.store) chk({tag, "_mem_wdata"}, bus.mem_wdata, v.mwdata);
   endtask

   task automatic run(input string tag, input vec_t v);
      for (int i = 0; i < 8 && !bus.req_ready; i++) step();
      chk({tag, "_req_ready"}, 32'(bus.req_ready), 32'h1);
      bus.req_valid  = 1'b1;
      bus.req_store  = v.store;
      bus.req_funct3 = v.f3;
      bus.req_addr   = v.addr;
      bus.req_wdata  = v.wdata;
      step();                                   // accept edge
      bus.req_valid  = 1'b0;
      bus.req_wdata  = 32'h0;
`ifdef LSU_MISALIGN_TRAP_EN
      if (v.mis) begin
         chk({tag, "_trap_no_mem"},  32'(bus.mem_valid),  32'h0);
         chk({tag, "_trap_resp_v"},  32'(bus.resp_valid), 32'h1);
         chk({tag, "_trap_fault"},   32'(bus.resp_fault), 32'h1);
         chk({tag, "_trap_rdata"},   bus.resp_rdata,      32'h0);
         step();
         chk({tag, "_trap_resp_end"}, 32'(bus.resp_valid), 32'h0);
         return;
      end
`endif
      chk_mem(tag, v);
      for (int i = 0; i < v.dly; i++) begin
         step();
         chk_mem({tag, "_stall"}, v);
      end
      bus.mem_ready = 1'b1;
      step();                                   // handshake edge -> WAIT
      bus.mem_ready = 1'b0;
      chk({tag, "_wait_mem_valid"},  32'(bus.mem_valid),  32'h0);
      chk({tag, "_wait_resp_valid"}, 32'(bus.resp_valid), 32'h0);
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = v.rdata;
      step();                                   // rvalid edge -> RESP
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = 32'h0;
      chk({tag, "_resp_valid"}, 32'(bus.resp_valid), 32'h1);
      chk({tag, "_resp_rdata"}, bus.resp_rdata,      v.resp);
      chk({tag, "_resp_fault"}, 32'(bus.resp_fault), 32'h0);
      step();
      chk({tag, "_resp_end"},   32'(bus.resp_valid), 32'h0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      bus.req_valid = 1'b0; bus.req_store = 1'b0; bus.req_funct3 = 3'h0;
      bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
      bus.mem_ready = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'h0;

      //            st  funct3           addr         wdata         rdata         maddr     strb     mwdata        resp          dly mis
      vt.push_back(mk(1, FUNCT3_STORE_SB, 32'h1003, 32'h0000_00AB, 32'hFFFF_FFFF, 30'h400, 4'b1000, 32'hABAB_ABAB, 32'h0,         0, 0));
      vt.push_back(mk(0, FUNCT3_LOAD_LB,  32'h2001, 32'h0,         32'h0000_8000, 30'h800, 4'b0000, 32'h0,         32'hFFFF_FF80, 0, 0));
      vt.push_back(mk(0, FUNCT3_LOAD_LBU, 32'h2001, 32'h0,         32'h0000_8000, 30'h800, 4'b0000, 32'h0,         32'h0000_0080, 0, 0));
      vt.push_back(mk(0, FUNCT3_LOAD_LH,  32'h2002, 32'h0,         32'h8001_0000, 30'h800, 4'b0000, 32'h0,         32'hFFFF_8001, 5, 0));
      vt.push_back(mk(1, FUNCT3_STORE_SW, 32'h3000, 32'hDEAD_BEEF, 32'h5555_5555, 30'hC00, 4'b1111, 32'hDEAD_BEEF, 32'h0,         0, 0));
      vt.push_back(mk(0, FUNCT3_LOAD_LW,  32'h3000, 32'h0,         32'hDEAD_BEEF, 30'hC00, 4'b0000, 32'h0,         32'hDEAD_BEEF, 0, 0));
      vt.push_back(mk(1, FUNCT3_STORE_SH, 32'h1002, 32'h1234_5678, 32'h0,         30'h400, 4'b1100, 32'h5678_5678, 32'h0,         1, 0));
      vt.push_back(mk(0, FUNCT3_LOAD_LHU, 32'h2002, 32'h0,         32'hF00D_1234, 30'h800, 4'b0000, 32'h0,         32'h0000_F00D, 0, 0));
      vt.push_back(mk(0, FUNCT3_LOAD_LH,  32'h2000, 32'h0,         32'hF00D_9234, 30'h800, 4'b0000, 32'h0,         32'hFFFF_9234, 0, 0));
      vt.push_back(mk(0, FUNCT3_LOAD_LB,  32'h2002, 32'h0,         32'h0045_0000, 30'h800, 4'b0000, 32'h0,         32'h0000_0045, 0, 0));
      vt.push_back(mk(0, FUNCT3_LOAD_LBU, 32'h2003, 32'h0,         32'h9A00_0000, 30'h800, 4'b0000, 32'h0,         32'h0000_009A, 0, 0));
      vt.push_back(mk(1, FUNCT3_STORE_SB, 32'h1000, 32'hFFFF_FF5A, 32'h0,         30'h400, 4'b0001, 32'h5A5A_5A5A, 32'h0,         2, 0));
      vt.push_back(mk(1, 3'd3,            32'h1004, 32'h0102_0304, 32'h0,         30'h401, 4'b1111, 32'h0102_0304, 32'h0,         0, 0));
      vt.push_back(mk(0, 3'd7,            32'h1008, 32'h0,         32'hCAFE_F00D, 30'h402, 4'b0000, 32'h0,         32'hCAFE_F00D, 0, 0));
      vt.push_back(mk(0, FUNCT3_LOAD_LW,  32'h3002, 32'h0,         32'h1234_5678, 30'hC00, 4'b0000, 32'h0,         32'h1234_5678, 0, 1));
      vt.push_back(mk(1, FUNCT3_STORE_SH, 32'h1001, 32'h0000_BEEF, 32'h0,         30'h400, 4'b0011, 32'hBEEF_BEEF, 32'h0,         0, 1));
      vt.push_back(mk(0, FUNCT3_LOAD_LH,  32'h2003, 32'h0,         32'h8001_0000, 30'h800, 4'b0000, 32'h0,         32'hFFFF_8001, 0, 1));

      reset = 1'b1;
      step();
      step();
      chk_reset_outputs("por");
      reset = 1'b0;
      step();

      for (int n = 0; n < vt.size(); n++) run($sformatf("v%0d", n), vt[n]);

      // Reset while WAITing for read data, then a late mem_rvalid.
      for (int i = 0; i < 8 && !bus.req_ready; i++) step();
      bus.req_valid = 1'b1; bus.req_store = 1'b0;
      bus.req_funct3 = FUNCT3_LOAD_LW; bus.req_addr = 32'h3000;
      step();
      bus.req_valid = 1'b0;
      chk("rst_issue_mem_valid", 32'(bus.mem_valid), 32'h1);
      bus.mem_ready = 1'b1;
      step();
      bus.mem_ready = 1'b0;
      reset = 1'b1;
      step();
      chk_reset_outputs("rst_wait");
      reset = 1'b0;
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = 32'hFFFF_FFFF;
      step();
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = 32'h0;
      chk("rst_late_rvalid_resp", 32'(bus.resp_valid), 32'h0);
      chk("rst_late_rvalid_mem",  32'(bus.mem_valid),  32'h0);
      chk("rst_late_rvalid_rd",   bus.resp_rdata,      32'h0);
      step();
      chk("rst_late_rvalid_resp2", 32'(bus.resp_valid), 32'h0);
      run("post_rst", mk(0, FUNCT3_LOAD_LH, 32'h2002, 32'h0, 32'h8001_0000, 30'h800,
                         4'b0000, 32'h0, 32'hFFFF_8001, 0, 0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/riscv_lsu.md
Name: riscv_lsu

Overview:
- Load/store unit sitting directly downstream of instruction decode. Consumes OPCODE_LOAD/OPCODE_STORE micro-ops, each carrying FUNCT3_LOAD_*/FUNCT3_STORE_* and an effective address.
- Drives a single-outstanding, word-wide data-memory handshake.
- Performs byte-lane steering, write-strobe generation and load sign/zero extension.
- Returns one response per request to writeback.

Parameters:
- XLEN, 32, data/address width; only 32 is supported.
- MEM_AW, 30, word-address width on the memory port, equal to XLEN-2.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  LSU can accept a request
- req_store  in  1  1 = store, 0 = load
- req_funct3  in  3  FUNCT3_LOAD_* or FUNCT3_STORE_* encoding
- req_addr  in  XLEN  effective byte address
- req_wdata  in  XLEN  store data (rs2), right-aligned
- mem_valid  out  1  memory request
- mem_ready  in  1  memory accepts request
- mem_addr  out  MEM_AW  word address
- mem_we  out  1  write enable
- mem_wstrb  out  4  byte strobes
- mem_wdata  out  XLEN  lane-steered write data
- mem_rvalid  in  1  read data / write ack valid
- mem_rdata  in  XLEN  raw read word
- resp_valid  out  1  one-cycle response pulse
- resp_rdata  out  XLEN  extended load result; 0 for stores
- resp_fault  out  1  misaligned access; meaningful only when LSU_MISALIGN_TRAP_EN is defined, otherwise tied 0

Behaviour:
- Reset values: req_ready=0, mem_valid=0, mem_we=0, mem_wstrb=0, mem_addr=0, mem_wdata=0, resp_valid=0, resp_rdata=0, resp_fault=0. FSM returns to IDLE.
- Reset mid-operation abandons any transaction. A late mem_rvalid arriving in IDLE is ignored.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, register store, funct3, addr[1:0], wdata-derived lanes and strobes, then go to ISSUE.
- ISSUE:
  - mem_valid=1; mem_addr, mem_we, mem_wstrb and mem_wdata are held stable until mem_ready.
  - On mem_valid&&mem_ready, go to WAIT.
- WAIT:
  - On mem_rvalid, capture the extended result into resp_rdata, then go to RESP.
  - mem_rvalid is honoured in the same cycle it arrives.
- RESP: resp_valid=1 for exactly one cycle, then go to IDLE.
- Minimum latency with zero-wait memory: accept at cycle 0; resp_valid at cycle 3. Back-to-back issue rate is 1 request per 4 cycles.
- Strobes (off = addr[1:0]):
  - SB: 4'b0001<<off.
  - SH: 4'b0011<<off, off in {0,2}.
  - SW: 4'b1111.
  - Loads: mem_wstrb=0, mem_we=0.
- Store data replication:
  - SB: wdata[7:0] copied to all 4 lanes.
  - SH: wdata[15:0] copied to both halves.
  - SW: wdata unchanged.
- Load extraction:
  - byte = rdata[8*off +: 8]; half = rdata[16*off[1] +: 16].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- Alignment rule: misaligned means LH/LHU/SH with off[0]=1, or LW/SW with off!=0.
- Undefined funct3 values (3,6,7 for loads; 3-7 for stores) are treated as word accesses.
- mem_addr = addr[XLEN-1:2].

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined: a misaligned request goes IDLE->RESP directly, with no memory transaction, resp_fault=1 and resp_rdata=0. Aligned accesses have resp_fault=0.
- Undefined: misalignment is not detected and resp_fault is tied to 0. SH uses off[1] only; LW/SW ignore off, giving a silently word-aligned access.

Decomposition:
- Shared opcodes package gains:
  - LSU state enum typedef.
  - Function lsu_is_misaligned(store, funct3, off).
  - Existing FUNCT3_LOAD_*/FUNCT3_STORE_* constants, reused unchanged.
- One sub-module, riscv_lsu_align: purely combinational strobe/steer/extend logic, reused by a future cache path.

Test Plan:
- SB addr=0x1003 wdata=0xAB: mem_addr=0x400, wstrb=4'b1000, wdata=0xABABABAB, resp_rdata=0 at cycle 3.
- LB addr=0x2001, rdata=0x0000_8000: resp_rdata=0xFFFF_FF80. LBU at the same address: resp_rdata=0x0000_0080.
- LH addr=0x2002, rdata=0x8001_0000, memory holds mem_ready low 5 cycles: request stable throughout; resp_rdata=0xFFFF_8001.
- SW addr=0x3000 wdata=0xDEADBEEF, then LW at the same address on the next req_ready: strobes 4'b1111, then 4'b0000; two distinct responses.
- LW addr=0x3002:
  - With LSU_MISALIGN_TRAP_EN: no mem_valid; resp_fault=1 one cycle after accept.
  - Without it: mem_addr=0xC00 and normal response.
- reset asserted in WAIT, then mem_rvalid pulses one cycle later: no resp_valid; all outputs at reset values; the next request completes normally.
